dcache: RTL
===========

# dcache

Direct-mapped, write-back data cache between the CPU core and the 32-bit-block data memory. Serves byte loads/stores from the ALU-address path. Returns load data that feeds `reg_file` write data (`IN`). Stalls the core via `BUSYWAIT`, which also gates register writes, until misses are serviced.

## Interface
- Parameters: none. Geometry is fixed at 8 blocks × 4 bytes. Constants live in the package.
- `CLK` in 1: single clock, rising-edge active.
- `RESET` in 1: asynchronous, active-high.
- `READ` in 1: CPU load request, held until `BUSYWAIT` is low.
- `WRITE` in 1: CPU store request, held until `BUSYWAIT` is low.
- `ADDRESS` in 8: byte address. Fields are `{tag[7:5], index[4:2], offset[1:0]}`.
- `WRITEDATA` in 8: store byte.
- `READDATA` out 8: load byte.
- `BUSYWAIT` out 1: CPU stall.
- `MEM_READ` out 1: block fetch request.
- `MEM_WRITE` out 1: block write-back request.
- `MEM_ADDRESS` out 6: block address, `{tag,index}`.
- `MEM_WRITEDATA` out 32: write-back block. Byte 0 is in `[7:0]`.
- `MEM_READDATA` in 32: fetched block.
- `MEM_BUSYWAIT` in 1: memory busy. Memory raises it combinationally in the same cycle a request rises. It drops for exactly one cycle at completion, which is the cycle `MEM_READDATA` is valid.

## Operation
- Storage per index:
  - `data[32]`
  - `tag[3]`
  - `valid`
  - `dirty`
- Hit: `valid[index] && tag[index]==ADDRESS[7:5]`, evaluated combinationally.
- `BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit)`.
- `READDATA`:
  - Combinational byte select of `data[index]` by offset.
  - Only meaningful when `READ` is asserted and `BUSYWAIT` is low.
  - Otherwise it holds the selected byte with no forced value.
- `READ` and `WRITE` asserted together: `WRITE` takes priority and is treated as a store.
- FSM states: `IDLE`, `WRITEBACK`, `FETCH`.
  - `IDLE`, hit with `WRITE`: on the posedge, write the byte into `data[index][offset]` and set `dirty`. Stay in `IDLE`.
  - `IDLE`, hit with `READ`: no state change.
  - `IDLE`, miss with `valid && dirty` → `WRITEBACK`.
  - `IDLE`, miss otherwise → `FETCH`.
  - `WRITEBACK`: drive `MEM_WRITE=1`, `MEM_ADDRESS={tag[index],index}`, `MEM_WRITEDATA=data[index]`. On a posedge with `MEM_BUSYWAIT==0` → `FETCH`.
  - `FETCH`: drive `MEM_READ=1`, `MEM_ADDRESS=ADDRESS[7:2]`. On a posedge with `MEM_BUSYWAIT==0`, load `data[index]=MEM_READDATA`, set `tag`, `valid=1`, `dirty=0`, then → `IDLE`.
- A store miss is handled as write-allocate. After the fill, the re-evaluation in `IDLE` hits and performs the store.
- `MEM_READ` and `MEM_WRITE` are never high together. Both are low in `IDLE`.

## Timing
- Reset (asynchronous):
  - `state=IDLE`, all `valid=0`, all `dirty=0`.
  - `MEM_READ=0`, `MEM_WRITE=0`, `MEM_ADDRESS=0`, `MEM_WRITEDATA=0`.
  - `BUSYWAIT` follows its equation, so it is high if a request is present.
  - Data and tag arrays are not cleared.
- Reset during `WRITEBACK` or `FETCH` aborts immediately. The memory request drops in the same cycle and no partial fill is committed.
- Hit: zero stall. `BUSYWAIT` stays low and a store commits at the next posedge.
- Clean miss: stall = 1 + F cycles, where F is the number of `FETCH` cycles including the completion cycle. `BUSYWAIT` falls in the first `IDLE` cycle after the fill.
- Dirty miss: stall = 1 + W + F cycles, where W is the number of `WRITEBACK` cycles.
- Request dropped mid-miss: the current `WRITEBACK`/`FETCH` sequence completes and the fill is kept. `BUSYWAIT` goes low once `READ` and `WRITE` are low.
- `ADDRESS` and the request must stay stable while `BUSYWAIT` is high. Changing them is a protocol violation with undefined data.
- Same-index thrash with alternating tags: every access misses. Correctness holds.

## Structure
- Package `dcache_pkg` holds:
  - `TAG_W=3`, `INDEX_W=3`, `OFFSET_W=2`, `BLOCK_W=32`, `NUM_BLOCKS=8`.
  - The state enum `{IDLE, WRITEBACK, FETCH}`.
- One natural sub-module: `dcache_ctrl`. It holds the FSM and the memory request/`BUSYWAIT` logic, taking hit/dirty/valid as inputs. Arrays and byte select stay in `dcache`.

## Test plan
- **Reset, then cold read:** `RESET` pulse, `READ` with `ADDRESS=0x05`, memory returns `0xDDCCBBAA` after 5 busy cycles.
  - Expect `MEM_READ=1` and `MEM_ADDRESS=0x01` for 6 cycles.
  - Then `READDATA=0xBB` with `BUSYWAIT` low, 7 cycles after the request.
- **Write hit:** after the above, `WRITE` `0x5A` to `0x06`.
  - Expect no stall.
  - A following `READ 0x06` returns `0x5A` with no memory traffic.
- **Dirty eviction:** `READ 0x26`, which has the same index and tag 1.
  - Expect `MEM_WRITE=1` with `MEM_ADDRESS=0x01` and `MEM_WRITEDATA=0xDD5ABBAA`.
  - Then `MEM_READ` with `MEM_ADDRESS=0x09`, then data returned.
- **Write miss allocate:** `WRITE` `0x77` to `0xE3` on a clean index.
  - Expect fetch of block `0x38`.
  - Then byte 3 becomes `0x77` and `dirty=1`, verified by a later eviction write-back.
- **Mid-fetch reset:** assert `RESET` in the 3rd `FETCH` cycle.
  - `MEM_READ` drops immediately and `BUSYWAIT` follows its equation.
  - A re-read of the same address misses again, with `valid=0`.
- **Simultaneous `READ`+`WRITE` on a hit:** the store occurs and `READDATA` shows the new byte the next cycle.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - geometry constants and controller state type for dcache
package dcache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 8;
    localparam int BADDR_W    = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - miss-handling FSM, memory request and CPU stall logic
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   READ, WRITE         CPU load/store request
//   HIT, VALID, DIRTY   lookup result and line status for the addressed index
//   MEM_BUSYWAIT        memory busy; low for one cycle at completion
//   BUSYWAIT            CPU stall
//   MEM_READ, MEM_WRITE block fetch / write-back request
//   FILL                load the fetched block into the addressed line
//   STORE               commit the CPU store byte into the addressed line
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic READ,
    input  logic WRITE,
    input  logic HIT,
    input  logic VALID,
    input  logic DIRTY,
    input  logic MEM_BUSYWAIT,
    output logic BUSYWAIT,
    output logic MEM_READ,
    output logic MEM_WRITE,
    output logic FILL,
    output logic STORE
);

    state_t state;
    state_t next_state;

    logic req;
    assign req = READ | WRITE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode the current state directly so that a reset aborts a
    // memory request in the same cycle it is asserted.
    always_comb begin
        next_state = state;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        FILL       = 1'b0;
        STORE      = 1'b0;
        case (state)
            IDLE: begin
                if (req && HIT) begin
                    // WRITE wins over a simultaneous READ
                    STORE = WRITE;
                end else if (req) begin
                    next_state = (VALID && DIRTY) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                MEM_WRITE = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    FILL       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign BUSYWAIT = req && !(state == IDLE && HIT);

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back byte data cache, 8 blocks x 4 bytes
//
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   READ, WRITE    CPU load/store request, held until BUSYWAIT is low
//   ADDRESS        byte address {tag[7:5], index[4:2], offset[1:0]}
//   WRITEDATA      store byte
//   READDATA       load byte (combinational select of the indexed block)
//   BUSYWAIT       CPU stall
//   MEM_READ       block fetch request
//   MEM_WRITE      block write-back request
//   MEM_ADDRESS    block address {tag,index}
//   MEM_WRITEDATA  write-back block, byte 0 in [7:0]
//   MEM_READDATA   fetched block
//   MEM_BUSYWAIT   memory busy
module dcache
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [7:0]         ADDRESS,
    input  logic [7:0]         WRITEDATA,
    output logic [7:0]         READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [BADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;

    assign addr_tag    = ADDRESS[7:5];
    assign addr_index  = ADDRESS[4:2];
    assign addr_offset = ADDRESS[1:0];

    logic [BLOCK_W-1:0]    data_arr [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_arr;
    logic [NUM_BLOCKS-1:0] dirty_arr;

    logic hit;
    logic fill;
    logic store;

    assign hit = valid_arr[addr_index] && (tag_arr[addr_index] == addr_tag);

    dcache_ctrl u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .HIT          (hit),
        .VALID        (valid_arr[addr_index]),
        .DIRTY        (dirty_arr[addr_index]),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .FILL         (fill),
        .STORE        (store)
    );

    // Line status is cleared by reset; data and tags are left as-is since
    // an invalid line never hits.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else if (fill) begin
            valid_arr[addr_index] <= 1'b1;
            dirty_arr[addr_index] <= 1'b0;
        end else if (store) begin
            dirty_arr[addr_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            data_arr[addr_index] <= MEM_READDATA;
            tag_arr[addr_index]  <= addr_tag;
        end else if (store) begin
            data_arr[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

    assign READDATA = data_arr[addr_index][{addr_offset, 3'b000} +: 8];

    // Write-back targets the resident line; a fetch targets the requested one.
    always_comb begin
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        if (MEM_WRITE) begin
            MEM_ADDRESS   = {tag_arr[addr_index], addr_index};
            MEM_WRITEDATA = data_arr[addr_index];
        end else if (MEM_READ) begin
            MEM_ADDRESS   = ADDRESS[7:2];
        end
    end

endmodule
